data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words stored; legal word index 0..DEPTH_WORDS-1.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 Port: ce  input  1  request valid from initiator.
REQ-006 Port: we  input  1  write request qualifier.
REQ-007 Port: rr  input  1  read request qualifier.
REQ-008 Port: addr  input  32  byte address; word index addr[31:2].
REQ-009 Port: wtData  input  32  write data.
REQ-010 Port: w_mask  input  4  byte write enables, bit i gates wtData[8i+7:8i].
REQ-011 Port: r_mask  input  4  byte read enables, bit i gates rdData[8i+7:8i].
REQ-012 Port: rdData  output  32  read data, valid only while ready=1.
REQ-013 Port: ready  output  1  one-cycle response strobe.
REQ-014 Port: err  output  1  error flag, valid only while ready=1.
REQ-015 Port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, WAIT, RESP; wait counter width 4 bits.
REQ-017 IDLE: ce=1 with exactly one of we/rr =1 -> latch addr, wtData, w_mask, r_mask, op; load counter with WAIT_CYCLES; go WAIT (or RESP if WAIT_CYCLES=0).
REQ-018 IDLE: ce=1 with we=1 and rr=1 -> accept as error request; ce=0 or we=rr=0 -> no action, stay IDLE.
REQ-019 WAIT: decrement counter each cycle; go RESP on cycle counter reaches 1; inputs ignored.
REQ-020 RESP: ready=1 for exactly one cycle, then IDLE unconditionally; no request accepted in RESP cycle.
REQ-021 Latency: ready asserts in cycle WAIT_CYCLES+1 after accept edge; next accept earliest cycle after ready.
REQ-022 Write commit: masked bytes of latched wtData written to word addr[31:2] on the edge entering RESP; unmasked bytes unchanged; w_mask=0000 is a legal no-op write.
REQ-023 Read: rdData in RESP = stored word with bytes where r_mask bit=0 forced to 0x00; value reflects all writes committed before the edge entering RESP.
REQ-024 Error cases: latched addr[1:0]!=00, addr[31:2]>=DEPTH_WORDS, or we=rr=1 -> RESP with err=1, rdData=0, no memory write.
REQ-025 ready=0 -> rdData=0 and err=0.
REQ-026 ce/we/rr changes during WAIT/RESP never alter latched request or memory.
REQ-027 Outputs registered; no combinational path from inputs to ready, err, rdData, busy.

Reset
REQ-028 rst=0 asynchronously forces state IDLE, counter 0, ready=0, err=0, rdData=0, busy=0.
REQ-029 Reset during WAIT aborts pending request: no write commit, no ready after release.
REQ-030 Memory array contents not modified by reset.
REQ-031 First request accepted on first rising edge with rst=1 and legal request.

Verification
REQ-032 WAIT_CYCLES=2: write addr=0x10, wtData=0xDEADBEEF, w_mask=1111 -> ready=1 exactly 3 cycles after accept, err=0; read addr=0x10 r_mask=1111 -> rdData=0xDEADBEEF.
REQ-033 Byte mask: after REQ-032, write 0x11223344 w_mask=0101 to 0x10 -> read r_mask=1111 returns 0xDE22BE44; read r_mask=0011 returns 0x0000BE44.
REQ-034 Errors: read addr=0x12 -> ready=1, err=1, rdData=0; write addr=4*DEPTH_WORDS -> err=1; request we=rr=1 -> err=1, memory unchanged.
REQ-035 Reset mid-op: write 0xCAFEF00D to 0x20 then rst=0 during WAIT -> outputs 0 immediately, no ready; later read 0x20 returns prior contents.
REQ-036 WAIT_CYCLES=0 back-to-back: ce held high with alternating write/read to 0x8 -> ready every 2nd cycle, busy toggles, read returns last written value.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed number of wait states and a one-cycle
// ready strobe carrying byte-masked read data or an error flag.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic        rr,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    input  logic [3:0]  w_mask,
    input  logic [3:0]  r_mask,
    output logic [31:0] rdData,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wmask;
    logic [3:0]  lat_rmask;
    logic        lat_we;
    logic        lat_both;
    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle;
    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic        cur_both;
    logic        bad;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wmask;
    logic [3:0]  cur_rmask;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem_word;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic [31:0] mask_bytes(input logic [31:0] word,
                                               input logic [3:0]  mask);
        logic [31:0] masked;
        masked = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) masked[8*i +: 8] = word[8*i +: 8];
        end
        return masked;
    endfunction

    // With zero wait states the response is formed on the accept edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        in_idle    = (state == ST_IDLE);
        accept     = in_idle && ce && (we || rr);
        cur_addr   = in_idle ? addr   : lat_addr;
        cur_wdata  = in_idle ? wtData : lat_wdata;
        cur_wmask  = in_idle ? w_mask : lat_wmask;
        cur_rmask  = in_idle ? r_mask : lat_rmask;
        cur_we     = in_idle ? (we && !rr) : lat_we;
        cur_both   = in_idle ? (we && rr)  : lat_both;
        enter_resp = rst && ((accept && (WAIT_CYCLES == 0)) ||
                             ((state == ST_WAIT) && (cnt <= 4'd1)));
        bad        = cur_both || (cur_addr[1:0] != 2'b00) ||
                     ({2'b00, cur_addr[31:2]} >= DEPTH_LIM);
        idx        = cur_addr[IDX_W+1:2];
        mem_word   = mem[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            ready  <= 1'b0;
            err    <= 1'b0;
            rdData <= 32'h0;
        end else begin
            ready  <= 1'b0;
            err    <= 1'b0;
            rdData <= 32'h0;
            if (enter_resp) begin
                ready  <= 1'b1;
                err    <= bad;
                rdData <= (bad || cur_we) ? 32'h0 : mask_bytes(mem_word, cur_rmask);
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= WAIT_LOAD;
                        state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wtData;
            lat_wmask <= w_mask;
            lat_rmask <= r_mask;
            lat_we    <= we && !rr;
            lat_both  <= we && rr;
        end
    end

    // Memory is never reset; a commit only happens on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !bad) begin
            mem[idx] <= merge_bytes(mem_word, cur_wdata, cur_wmask);
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: one instance with two wait states, one with none.
module tb_data_mem_resp;

    localparam int WAIT0 = 2;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        ce0 = 0, we0 = 0, rr0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic [3:0]  wm0 = 0, rm0 = 0;
    logic [31:0] rd0;
    logic        rdy0, err0, busy0;

    logic        ce1 = 0, we1 = 0, rr1 = 0;
    logic [31:0] addr1 = 0, wd1 = 0;
    logic [3:0]  wm1 = 0, rm1 = 0;
    logic [31:0] rd1;
    logic        rdy1, err1, busy1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    bit          obs_ok;
    int          obs_lat;
    logic [31:0] obs_data;
    logic        obs_err;
    logic        obs_after;
    logic [31:0] model1;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT0)) u0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we0), .rr(rr0), .addr(addr0),
        .wtData(wd0), .w_mask(wm0), .r_mask(rm0), .rdData(rd0),
        .ready(rdy0), .err(err0), .busy(busy0)
    );

    data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .ce(ce1), .we(we1), .rr(rr1), .addr(addr1),
        .wtData(wd1), .w_mask(wm1), .r_mask(rm1), .rdData(rd1),
        .ready(rdy1), .err(err1), .busy(busy1)
    );

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Issue one request on u0, scramble the data inputs while it is pending,
    // then wait (bounded) for the ready strobe.
    task automatic run_req(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] wm, input logic [3:0] rm);
        @(negedge clk);
        ce0 = 1; we0 = w; rr0 = r; addr0 = a; wd0 = d; wm0 = wm; rm0 = rm;
        @(negedge clk);
        ce0 = 0; we0 = 0; rr0 = 0; addr0 = ~a; wd0 = ~d; wm0 = ~wm; rm0 = ~rm;
        obs_ok = 0; obs_lat = 0; obs_data = 'x; obs_err = 'x; obs_after = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (rdy0) begin
                obs_ok = 1; obs_lat = n; obs_data = rd0; obs_err = err0;
                break;
            end
            @(negedge clk);
        end
        if (obs_ok) begin
            @(negedge clk);
            obs_after = rdy0;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err0); end
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdData: got %h expected 0", rd0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (busy1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL reset_u1: got busy %b ready %b expected 0 0", busy1, rdy1); end
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic check_resp(input string name);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (obs_ok !== 1'b1) begin
            errors++; $display("FAIL %s_timeout: got no ready expected ready", name);
        end else begin
            checks++; if (obs_lat != WAIT0 + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, obs_lat, WAIT0 + 1); end
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL %s_err: got %b expected %b", name, obs_err, e.err); end
            if (e.chk) begin
                checks++; if (obs_data !== e.data) begin errors++; $display("FAIL %s_data: got %h expected %h", name, obs_data, e.data); end
            end
            checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL %s_strobe: got %b expected 0", name, obs_after); end
        end
    endtask

    task automatic test_write_read();
        sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        run_req(1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 4'b0000);
        check_resp("wr_full");
        sb.push_back('{err: 1'b0, data: 32'hDEADBEEF, chk: 1'b1});
        run_req(0, 1, 32'h10, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_full");
    endtask

    task automatic test_byte_mask();
        sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        run_req(1, 0, 32'h10, 32'h11223344, 4'b0101, 4'b0000);
        check_resp("wr_mask0101");
        sb.push_back('{err: 1'b0, data: 32'hDE22BE44, chk: 1'b1});
        run_req(0, 1, 32'h10, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_merged");
        sb.push_back('{err: 1'b0, data: 32'h0000BE44, chk: 1'b1});
        run_req(0, 1, 32'h10, 32'h0, 4'b0000, 4'b0011);
        check_resp("rd_mask0011");
        sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        run_req(1, 0, 32'h10, 32'h55555555, 4'b0000, 4'b0000);
        check_resp("wr_nomask");
        sb.push_back('{err: 1'b0, data: 32'hDE22BE44, chk: 1'b1});
        run_req(0, 1, 32'h10, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_after_nomask");
    endtask

    task automatic test_errors();
        sb.push_back('{err: 1'b1, data: 32'h0, chk: 1'b1});
        run_req(0, 1, 32'h12, 32'h0, 4'b0000, 4'b1111);
        check_resp("err_misaligned");
        sb.push_back('{err: 1'b1, data: 32'h0, chk: 1'b1});
        run_req(1, 0, 32'h1000, 32'h12345678, 4'b1111, 4'b0000);
        check_resp("err_range");
        sb.push_back('{err: 1'b1, data: 32'h0, chk: 1'b1});
        run_req(1, 1, 32'h10, 32'hFFFFFFFF, 4'b1111, 4'b1111);
        check_resp("err_both");
        sb.push_back('{err: 1'b0, data: 32'hDE22BE44, chk: 1'b1});
        run_req(0, 1, 32'h10, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_unchanged");
        sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        run_req(1, 0, 32'hFFC, 32'h0BADF00D, 4'b1111, 4'b0000);
        check_resp("wr_last_word");
        sb.push_back('{err: 1'b0, data: 32'h0BADF00D, chk: 1'b1});
        run_req(0, 1, 32'hFFC, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_last_word");
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        run_req(1, 0, 32'h20, 32'h01020304, 4'b1111, 4'b0000);
        check_resp("wr_prior");
        @(negedge clk);
        ce0 = 1; we0 = 1; rr0 = 0; addr0 = 32'h20; wd0 = 32'hCAFEF00D; wm0 = 4'b1111;
        @(negedge clk);
        ce0 = 0; we0 = 0;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_pending: got busy %b expected 1", busy0); end
        rst = 0;
        #1;
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0 || err0 !== 1'b0 || rd0 !== 32'h0) begin
            errors++; $display("FAIL midrst_async: got busy %b ready %b err %b rdData %h expected 0 0 0 0", busy0, rdy0, err0, rd0);
        end
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (rdy0) seen = 1;
        end
        rst = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rdy0 || busy0) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_ready: got ready/busy after abort expected none"); end
        sb.push_back('{err: 1'b0, data: 32'h01020304, chk: 1'b1});
        run_req(0, 1, 32'h20, 32'h0, 4'b0000, 4'b1111);
        check_resp("rd_after_abort");
    endtask

    task automatic drive_b2b(input int i);
        logic [31:0] v;
        logic [3:0]  m;
        ce1 = 1; addr1 = 32'h8; rm1 = 4'b1111;
        if (i % 2 == 0) begin
            v = 32'hA5A50000 + 32'(i * 32'h1111);
            m = (i == 4) ? 4'b0011 : 4'b1111;
            we1 = 1; rr1 = 0; wd1 = v; wm1 = m;
            model1 = model_merge(model1, v, m);
            sb.push_back('{err: 1'b0, data: 32'h0, chk: 1'b0});
        end else begin
            we1 = 0; rr1 = 1; wd1 = 32'h0; wm1 = 4'b0000;
            sb.push_back('{err: 1'b0, data: model1, chk: 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        model1 = 32'h0;
        @(negedge clk);
        drive_b2b(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (rdy1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL b2b_resp%0d: got ready %b busy %b expected 1 1", i, rdy1, busy1); end
            checks++; if (err1 !== e.err) begin errors++; $display("FAIL b2b_err%0d: got %b expected %b", i, err1, e.err); end
            if (e.chk) begin
                checks++; if (rd1 !== e.data) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, rd1, e.data); end
            end
            if (i < 5) drive_b2b(i + 1);
            else begin ce1 = 0; we1 = 0; rr1 = 0; end
            @(negedge clk);
            checks++; if (rdy1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got ready %b busy %b expected 0 0", i, rdy1, busy1); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
